// File: rtl/fp_cmp_pkg.sv
// Shared types and helpers for the sequential FP magnitude comparator.
// The operand is walked one byte per cycle, so the byte width lives here.
package fp_cmp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    // All-ones mask.  Optionally the operand MSB (the FP sign bit) is cleared.
    function automatic logic [63:0] sign_mask(input int nbytes, input bit mask_sign);
        logic [63:0] m;
        m = '1;
        if (mask_sign) begin
            m[nbytes*BYTE_W-1] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/fp_byte_cmp.sv
// Combinational unsigned 8-bit comparator; equal is implied when neither flag is set.
module fp_byte_cmp
    import fp_cmp_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    output logic              less_o,
    output logic              greater_o
);

    assign less_o    = (a_i < b_i);
    assign greater_o = (a_i > b_i);

endmodule

// File: rtl/fp_mag_cmp_seq.sv
// Multi-cycle |A| vs |B| comparator: one shared byte comparator walks the
// captured operands MSB byte first, with optional early exit on the first difference.
module fp_mag_cmp_seq
    import fp_cmp_pkg::*;
#(
    parameter int NUM_BYTES  = 4,
    parameter int EARLY_EXIT = 1,
    parameter int MASK_SIGN  = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [8*NUM_BYTES-1:0]           i_data_a,
    input  logic [8*NUM_BYTES-1:0]           i_data_b,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_less,
    output logic                             o_equal,
    output logic [$clog2(NUM_BYTES+1)-1:0]   o_bytes_used,
    output logic [1:0]                       o_dbg_state
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam logic [W-1:0] MASK = W'(sign_mask(NUM_BYTES, MASK_SIGN != 0));

    state_e              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                decided_q, decided_d;
    logic                less_q, less_d;
    logic                equal_q, equal_d;
    logic [CNT_W-1:0]    used_q, used_d;

    logic [NUM_BYTES-1:0][BYTE_W-1:0] a_bytes;
    logic [NUM_BYTES-1:0][BYTE_W-1:0] b_bytes;
    logic                less_b;
    logic                greater_b;
    logic                byte_ne;
    logic                cmp_exit;

    assign a_bytes = a_q;
    assign b_bytes = b_q;

    fp_byte_cmp u_byte_cmp (
        .a_i       (a_bytes[idx_q]),
        .b_i       (b_bytes[idx_q]),
        .less_o    (less_b),
        .greater_o (greater_b)
    );

    assign byte_ne  = less_b | greater_b;
    assign cmp_exit = ((EARLY_EXIT != 0) && byte_ne) || (idx_q == '0);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = CMP;
            CMP:     if (cmp_exit) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_ready     = (state_q == IDLE) && i_rst_n;
        o_valid     = (state_q == DONE);
        o_dbg_state = state_q;
    end

    // Datapath next values; result registers only move in CMP, so DONE holds them.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        less_d    = less_q;
        equal_d   = equal_q;
        used_d    = used_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d       = i_data_a & MASK;
                    b_d       = i_data_b & MASK;
                    idx_d     = IDX_W'(NUM_BYTES - 1);
                    decided_d = 1'b0;
                end
            end
            CMP: begin
                if (byte_ne && !decided_q) begin
                    less_d    = less_b;
                    equal_d   = 1'b0;
                    decided_d = 1'b1;
                end
                if (cmp_exit) begin
                    used_d = CNT_W'(NUM_BYTES - int'(idx_q));
                    if (!decided_q && !byte_ne) begin
                        less_d  = 1'b0;
                        equal_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            used_q    <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            used_q    <= used_d;
        end
    end

    assign o_less       = less_q;
    assign o_equal      = equal_q;
    assign o_bytes_used = used_q;

endmodule

// File: tb/tb_fp_mag_cmp_seq.sv
// Bench for fp_mag_cmp_seq: three parameterisations driven by directed vectors,
// checked against a whole-word arithmetic model plus hand-computed literals.
module tb_fp_mag_cmp_seq;

    localparam int NB = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v_in   [ND];
    logic        rdy_in [ND];
    logic [31:0] a_in   [ND];
    logic [31:0] b_in   [ND];
    logic        or_o   [ND];
    logic        ov_o   [ND];
    logic        less_o [ND];
    logic        eq_o   [ND];
    logic [2:0]  bu_o   [ND];
    logic [1:0]  st_o   [ND];

    int total = 0;
    int bad = 0;

    logic [4:0] exp_q0[$];
    logic [4:0] exp_q1[$];
    logic [4:0] exp_q2[$];

    fp_mag_cmp_seq #(.NUM_BYTES(4), .EARLY_EXIT(1), .MASK_SIGN(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v_in[0]), .o_ready(or_o[0]),
        .i_data_a(a_in[0]), .i_data_b(b_in[0]), .o_valid(ov_o[0]), .i_ready(rdy_in[0]),
        .o_less(less_o[0]), .o_equal(eq_o[0]), .o_bytes_used(bu_o[0]), .o_dbg_state(st_o[0])
    );
    fp_mag_cmp_seq #(.NUM_BYTES(4), .EARLY_EXIT(0), .MASK_SIGN(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v_in[1]), .o_ready(or_o[1]),
        .i_data_a(a_in[1]), .i_data_b(b_in[1]), .o_valid(ov_o[1]), .i_ready(rdy_in[1]),
        .o_less(less_o[1]), .o_equal(eq_o[1]), .o_bytes_used(bu_o[1]), .o_dbg_state(st_o[1])
    );
    fp_mag_cmp_seq #(.NUM_BYTES(4), .EARLY_EXIT(1), .MASK_SIGN(0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v_in[2]), .o_ready(or_o[2]),
        .i_data_a(a_in[2]), .i_data_b(b_in[2]), .o_valid(ov_o[2]), .i_ready(rdy_in[2]),
        .o_less(less_o[2]), .o_equal(eq_o[2]), .o_bytes_used(bu_o[2]), .o_dbg_state(st_o[2])
    );

    function automatic int ee_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int mk_of(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    // Whole-word model: {less, equal, bytes_used}
    function automatic logic [4:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input int ee, input int mk);
        logic [31:0] ma;
        logic [31:0] mb;
        int used;
        ma = a;
        mb = b;
        if (mk != 0) begin
            ma[31] = 1'b0;
            mb[31] = 1'b0;
        end
        used = NB;
        if (ee != 0) begin
            for (int j = 0; j < NB; j++) begin
                if (ma[8*j +: 8] != mb[8*j +: 8]) used = NB - j;
            end
        end
        return {(ma < mb), (ma == mb), 3'(used)};
    endfunction

    function automatic void q_push(input int i, input logic [4:0] v);
        case (i)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [4:0] q_front(input int i);
        case (i)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    function automatic void q_drop(input int i);
        case (i)
            0:       void'(exp_q0.pop_front());
            1:       void'(exp_q1.pop_front());
            default: void'(exp_q2.pop_front());
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle a result is valid it must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < ND; i++) begin
                if (ov_o[i]) begin
                    if (q_size(i) == 0) begin
                        check($sformatf("sb_unexpected_dut%0d", i), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("sb_result_dut%0d", i),
                              {27'd0, less_o[i], eq_o[i], bu_o[i]}, {27'd0, q_front(i)});
                        if (rdy_in[i]) q_drop(i);
                    end
                    check($sformatf("excl_dut%0d", i), {31'd0, less_o[i] & eq_o[i]}, 32'd0);
                end
            end
        end
    end

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                        input int exp_k);
        int n;
        n = 0;
        while (!or_o[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", {31'd0, or_o[i]}, 32'd1);
        v_in[i] = 1'b1;
        a_in[i] = a;
        b_in[i] = b;
        @(posedge clk); #1;
        v_in[i] = 1'b0;
        a_in[i] = $urandom;
        b_in[i] = $urandom;
        q_push(i, model(a, b, ee_of(i), mk_of(i)));
        n = 0;
        while (!ov_o[i] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("latency_dut%0d", i), n, exp_k);
    endtask

    task automatic take(input int i, input int hold, input logic exp_less,
                        input logic exp_eq, input logic [2:0] exp_used);
        check("lit_less", {31'd0, less_o[i]}, {31'd0, exp_less});
        check("lit_equal", {31'd0, eq_o[i]}, {31'd0, exp_eq});
        check("lit_used", {29'd0, bu_o[i]}, {29'd0, exp_used});
        for (int h = 0; h < hold; h++) begin
            v_in[i] = 1'($urandom_range(0, 1));
            a_in[i] = $urandom;
            b_in[i] = $urandom;
            @(posedge clk); #1;
            check("bp_ready_low", {31'd0, or_o[i]}, 32'd0);
            check("bp_valid_high", {31'd0, ov_o[i]}, 32'd1);
            check("bp_less_hold", {31'd0, less_o[i]}, {31'd0, exp_less});
            check("bp_used_hold", {29'd0, bu_o[i]}, {29'd0, exp_used});
        end
        v_in[i] = 1'b0;
        rdy_in[i] = 1'b1;
        @(posedge clk); #1;
        rdy_in[i] = 1'b0;
        check("post_valid_low", {31'd0, ov_o[i]}, 32'd0);
        check("post_ready_high", {31'd0, or_o[i]}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < ND; i++) begin
            v_in[i] = 1'b0;
            rdy_in[i] = 1'b0;
            a_in[i] = '0;
            b_in[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            check("rst_ready", {31'd0, or_o[i]}, 32'd0);
            check("rst_valid", {31'd0, ov_o[i]}, 32'd0);
            check("rst_less", {31'd0, less_o[i]}, 32'd0);
            check("rst_equal", {31'd0, eq_o[i]}, 32'd0);
            check("rst_used", {29'd0, bu_o[i]}, 32'd0);
            check("rst_state", {30'd0, st_o[i]}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, or_o[0]}, 32'd1);

        // Early exit, signed-magnitude masking on dut0
        send(0, 32'h3F800000, 32'h40000000, 1); take(0, 0, 1'b1, 1'b0, 3'd1);
        send(0, 32'h40490FDB, 32'h40490FDA, 4); take(0, 0, 1'b0, 1'b0, 3'd4);
        send(0, 32'h12345678, 32'h12345678, 4); take(0, 0, 1'b0, 1'b1, 3'd4);
        send(0, 32'h80000000, 32'h00000000, 4); take(0, 0, 1'b0, 1'b1, 3'd4);
        send(0, 32'hBF800000, 32'h3F800000, 4); take(0, 0, 1'b0, 1'b1, 3'd4);
        send(0, 32'h00000000, 32'h00000000, 4); take(0, 0, 1'b0, 1'b1, 3'd4);
        send(0, 32'h00000100, 32'h00000200, 3); take(0, 0, 1'b1, 1'b0, 3'd3);
        send(0, 32'h3F800000, 32'h40000000, 1); take(0, 5, 1'b1, 1'b0, 3'd1);

        // Fixed latency
        send(1, 32'h3F800000, 32'h40000000, 4); take(1, 0, 1'b1, 1'b0, 3'd4);
        send(1, 32'h40000000, 32'h3F800000, 4); take(1, 0, 1'b0, 1'b0, 3'd4);

        // Raw unsigned compare
        send(2, 32'hBF800000, 32'h3F800000, 1); take(2, 0, 1'b0, 1'b0, 3'd1);
        send(2, 32'h80000000, 32'h00000000, 1); take(2, 0, 1'b0, 1'b0, 3'd1);
        send(2, 32'h3F800000, 32'hBF800000, 1); take(2, 2, 1'b1, 1'b0, 3'd1);

        // Reset while dut0 is in CMP at idx=2
        @(posedge clk); #1;
        v_in[0] = 1'b1;
        a_in[0] = 32'h12345678;
        b_in[0] = 32'h12345678;
        @(posedge clk); #1;
        v_in[0] = 1'b0;
        @(posedge clk); #1;
        check("mid_state_cmp", {30'd0, st_o[0]}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_state", {30'd0, st_o[0]}, 32'd0);
        check("rst_mid_valid", {31'd0, ov_o[0]}, 32'd0);
        check("rst_mid_ready", {31'd0, or_o[0]}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_mid_ready_back", {31'd0, or_o[0]}, 32'd1);
        repeat (6) begin
            @(posedge clk); #1;
            check("no_ghost_result", {31'd0, ov_o[0]}, 32'd0);
        end
        send(0, 32'h40490FDA, 32'h40490FDB, 4); take(0, 0, 1'b1, 1'b0, 3'd4);

        repeat (2) @(posedge clk);
        for (int i = 0; i < ND; i++) begin
            check($sformatf("sb_drained_dut%0d", i), q_size(i), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
